// File: rtl/gcd_stream_unit.sv
// gcd_stream_unit: iterative-subtraction GCD over a WIDTH-bit datapath with
// ready/valid handshakes on the operand and result streams.
// The result is held stable until the consumer takes it.
// Optional macro GCD_CYCLES_EN adds io_out_cycles, which reports how many
// cycles the computation spent in BUSY.
module gcd_stream_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_bits_a,
   input  logic [WIDTH-1:0] io_in_bits_b,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_bits
`ifdef GCD_CYCLES_EN
   ,
   output logic [WIDTH:0]   io_out_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_x, r_y, r_res;
   logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_res_nxt;

   // State and datapath registers; reset drops any in-flight or held result.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_res   <= w_res_nxt;
      end
   end

   // Next-state and datapath update: one subtraction (or finish) per BUSY cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_res_nxt   = r_res;
      case (r_state)
         IDLE: begin
            if (io_in_valid) begin
               w_x_nxt     = io_in_bits_a;
               w_y_nxt     = io_in_bits_b;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            // Zero checks come first so gcd(a,0)=a, gcd(0,b)=b, gcd(0,0)=0.
            if (r_y == '0) begin
               w_res_nxt   = r_x;
               w_state_nxt = DONE;
            end else if (r_x == '0) begin
               w_res_nxt   = r_y;
               w_state_nxt = DONE;
            end else if (r_x > r_y) begin
               w_x_nxt = r_x - r_y;
            end else begin
               // x==y lands here and drives y to zero, finishing next cycle.
               w_y_nxt = r_y - r_x;
            end
         end
         DONE: begin
            if (io_out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign io_in_ready  = (r_state == IDLE);
   assign io_out_valid = (r_state == DONE);
   assign io_out_bits  = r_res;

`ifdef GCD_CYCLES_EN
   // One extra bit so the worst case (2^WIDTH BUSY cycles) does not wrap.
   logic [WIDTH:0] r_cycles;

   // Cycle counter: cleared on accept, counts BUSY cycles, frozen in DONE.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cycles <= '0;
      end else if (r_state == IDLE && io_in_valid) begin
         r_cycles <= '0;
      end else if (r_state == BUSY) begin
         r_cycles <= r_cycles + (WIDTH+1)'(1);
      end
   end

   assign io_out_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_gcd_stream_unit.sv
// Bench for gcd_stream_unit: a table of directed vectors, hand sequences for
// backpressure, ignored inputs while busy and mid-flight reset, a WIDTH=8
// worst-case run, and randomized operands checked against a Euclid model.
module tb_gcd_stream_unit;

   logic clock = 1'b0;
   logic reset;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] a16, b16, out_bits16;
   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, out_bits8;
`ifdef GCD_CYCLES_EN
   logic [16:0] cycles16;
   logic [8:0]  cycles8;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   gcd_stream_unit #(.WIDTH(16)) dut16 (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (in_valid16),
      .io_in_ready  (in_ready16),
      .io_in_bits_a (a16),
      .io_in_bits_b (b16),
      .io_out_valid (out_valid16),
      .io_out_ready (out_ready16),
      .io_out_bits  (out_bits16)
`ifdef GCD_CYCLES_EN
      ,
      .io_out_cycles(cycles16)
`endif
   );

   gcd_stream_unit #(.WIDTH(8)) dut8 (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (in_valid8),
      .io_in_ready  (in_ready8),
      .io_in_bits_a (a8),
      .io_in_bits_b (b8),
      .io_out_valid (out_valid8),
      .io_out_ready (out_ready8),
      .io_out_bits  (out_bits8)
`ifdef GCD_CYCLES_EN
      ,
      .io_out_cycles(cycles8)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      int          lat;
      int          hold;
      bit          noise;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: Euclid by division. gcd from the remainder chain; the number
   // of subtraction steps equals the sum of the quotients, plus one finishing cycle.
   function automatic longint ref_gcd(input longint a, input longint b);
      longint t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int ref_lat(input longint a, input longint b);
      longint t;
      longint s;
      if (a == 0 || b == 0) return 1;
      s = 0;
      while (b != 0) begin
         s += a / b;
         t = a % b;
         a = b;
         b = t;
      end
      return int'(s) + 1;
   endfunction

   // One transaction on the 16-bit unit; checks result, hold stability and
   // return to idle, and reports the observed accept-to-valid latency.
   task automatic run16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int hold,
                        input bit noise, output int lat);
      bit to;
      @(negedge clock);
      chk("in_ready_before_accept", in_ready16, 1);
      in_valid16  = 1'b1;
      a16         = a;
      b16         = b;
      out_ready16 = 1'b0;
      @(posedge clock); #1;
      in_valid16 = 1'b0;
      lat = 0;
      to  = 1'b1;
      for (int c = 0; c < 70000; c++) begin
         if (noise) begin
            in_valid16 = c[0];
            a16 = 16'd3;
            b16 = 16'd6;
         end
         @(posedge clock); #1;
         lat++;
         if (out_valid16) begin
            to = 1'b0;
            break;
         end
      end
      in_valid16 = 1'b0;
      if (to) begin
         checks++;
         errors++;
         $display("FAIL timeout16: no out_valid within %0d cycles for a=%0d b=%0d", lat, a, b);
         return;
      end
      chk("result", out_bits16, exp_res);
      chk("in_ready_in_done", in_ready16, 0);
`ifdef GCD_CYCLES_EN
      chk("cycles16", cycles16, lat);
`endif
      for (int h = 0; h < hold; h++) begin
         @(posedge clock); #1;
         chk("hold_valid", out_valid16, 1);
         chk("hold_bits", out_bits16, exp_res);
         chk("hold_in_ready", in_ready16, 0);
      end
      out_ready16 = 1'b1;
      @(posedge clock); #1;
      out_ready16 = 1'b0;
      chk("valid_after_handshake", out_valid16, 0);
      chk("idle_after_handshake", in_ready16, 1);
   endtask

   initial begin
      int          lat;
      bit          to;
      logic [15:0] ra, rb, f;

      tbl[0] = '{a:16'd48,  b:16'd32, res:16'd16, lat:4,  hold:0,  noise:1'b0};
      tbl[1] = '{a:16'd7,   b:16'd3,  res:16'd1,  lat:6,  hold:10, noise:1'b0};
      tbl[2] = '{a:16'd0,   b:16'd5,  res:16'd5,  lat:1,  hold:0,  noise:1'b0};
      tbl[3] = '{a:16'd9,   b:16'd0,  res:16'd9,  lat:1,  hold:0,  noise:1'b0};
      tbl[4] = '{a:16'd0,   b:16'd0,  res:16'd0,  lat:1,  hold:1,  noise:1'b0};
      tbl[5] = '{a:16'd100, b:16'd10, res:16'd10, lat:11, hold:0,  noise:1'b1};
      tbl[6] = '{a:16'd3,   b:16'd7,  res:16'd1,  lat:6,  hold:2,  noise:1'b1};
      tbl[7] = '{a:16'd12,  b:16'd8,  res:16'd4,  lat:4,  hold:0,  noise:1'b0};

      reset = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
      in_valid8  = 1'b0; a8  = '0; b8  = '0; out_ready8  = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("reset_in_ready", in_ready16, 1);
      chk("reset_out_valid", out_valid16, 0);
      chk("reset_out_bits", out_bits16, 0);
`ifdef GCD_CYCLES_EN
      chk("reset_cycles", cycles16, 0);
`endif

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         run16(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].hold, tbl[i].noise, lat);
         chk("latency", lat, tbl[i].lat);
      end

      // Reset two edges into a computation; the held result (4) is dropped.
      @(negedge clock);
      in_valid16 = 1'b1; a16 = 16'd48; b16 = 16'd32;
      @(posedge clock); #1;
      in_valid16 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("midflight_reset_out_valid", out_valid16, 0);
      chk("midflight_reset_in_ready", in_ready16, 1);
      chk("midflight_reset_out_bits", out_bits16, 0);
      run16(16'd12, 16'd8, 16'd4, 0, 1'b0, lat);
      chk("after_reset_latency", lat, 4);

      // Randomized operands with a shared factor, occasional zeros.
      for (int i = 0; i < 30; i++) begin
         f  = 16'($urandom_range(1, 200));
         ra = f * 16'($urandom_range(0, 40));
         rb = f * 16'($urandom_range(0, 40));
         if ($urandom_range(0, 9) == 0) ra = 16'd0;
         run16(ra, rb, 16'(ref_gcd(ra, rb)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
         chk("rand_latency", lat, ref_lat(ra, rb));
      end

      // WIDTH=8 worst case: (255,1) takes 2^8 cycles.
      @(negedge clock);
      chk("w8_in_ready", in_ready8, 1);
      in_valid8 = 1'b1; a8 = 8'd255; b8 = 8'd1; out_ready8 = 1'b1;
      @(posedge clock); #1;
      in_valid8 = 1'b0;
      lat = 0;
      to  = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clock); #1;
         lat++;
         if (out_valid8) begin
            to = 1'b0;
            break;
         end
      end
      if (to) begin
         checks++;
         errors++;
         $display("FAIL timeout8: no out_valid within %0d cycles", lat);
      end else begin
         chk("w8_latency", lat, 256);
         chk("w8_result", out_bits8, 1);
`ifdef GCD_CYCLES_EN
         chk("w8_cycles", cycles8, 256);
`endif
         @(posedge clock); #1;
         chk("w8_valid_after_handshake", out_valid8, 0);
         chk("w8_idle_after_handshake", in_ready8, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
